// File: rtl/game_sequencer.sv
// game_sequencer: frame-paced square-pong controller with per-frame ADC speed sampling.
// Define GAME_SEQ_ADC_TIMEOUT_EN to bound the ADC wait with a cycle timeout.
module game_sequencer #(
  parameter int SQUARE_DIM   = 50,
  parameter int HOME_X       = 285,
  parameter int HOME_Y       = 215,
  parameter int LEFT_GOAL    = 160,
  parameter int RIGHT_GOAL   = 430,
  parameter int WIN_SCORE    = 5,
  parameter int SPEED_SHIFT  = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int ADC_TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       startGame,
  input  logic       player,
  input  logic [7:0] moveSpeed,
  input  logic       eoc,
  output logic       adc_start,
  output logic [9:0] squareX,
  output logic [8:0] squareY,
  output logic [7:0] leftsc,
  output logic [7:0] rightsc,
  output logic       showTitle,
  output logic       winnerLeft,
  output logic       winnerRight,
  output logic [2:0] state,
  output logic       adc_timeout
);

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_WIN   = 3'd4
  } st_t;

  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [9:0]  HX     = 10'(HOME_X);
  localparam logic [8:0]  HY     = 9'(HOME_Y);
  localparam logic [10:0] L_GOAL = 11'(LEFT_GOAL);
  localparam logic [10:0] R_GOAL = 11'(RIGHT_GOAL);
  localparam logic [7:0]  WIN    = 8'(WIN_SCORE);
  // the square must never leave the 10-bit coordinate space
  localparam logic [10:0] X_LIM  = 11'(1024 - SQUARE_DIM);

  st_t           r_state, w_state_nxt;
  logic [9:0]    r_x, w_x_nxt;
  logic [7:0]    r_left, r_right;
  logic [7:0]    w_left_nxt, w_right_nxt;
  logic [7:0]    w_left_inc, w_right_inc;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_speed;
  logic          r_wait, r_adc_start;
  logic          r_title, r_wl, r_wr;
  logic          w_title_nxt, w_wl_nxt, w_wr_nxt;
  logic [10:0]   w_step, w_next;
  logic          w_off_left, w_off_right;
  logic          w_active, w_to_hit;

  assign w_step = 11'(r_speed >> SPEED_SHIFT);
  assign w_next = player ? {1'b0, r_x} - w_step
                         : {1'b0, r_x} + w_step;
  assign w_off_left  = (player & w_next[10])
                     | (w_next < L_GOAL);
  assign w_off_right = (w_next > R_GOAL)
                     | (w_next > X_LIM);

  assign w_left_inc  = (r_left == 8'hFF) ? r_left
                                         : r_left + 8'd1;
  assign w_right_inc = (r_right == 8'hFF) ? r_right
                                          : r_right + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_TITLE;
      r_x     <= HX;
      r_left  <= '0;
      r_right <= '0;
      r_cnt   <= '0;
      r_title <= 1'b1;
      r_wl    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_left  <= w_left_nxt;
      r_right <= w_right_nxt;
      r_cnt   <= w_cnt_nxt;
      r_title <= w_title_nxt;
      r_wl    <= w_wl_nxt;
      r_wr    <= w_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_left_nxt  = r_left;
    w_right_nxt = r_right;
    w_cnt_nxt   = r_cnt;
    if (screenEnd) begin
      unique case (r_state)
        S_TITLE: begin
          if (startGame) begin
            w_left_nxt  = '0;
            w_right_nxt = '0;
            w_cnt_nxt   = '0;
            w_x_nxt     = HX;
            w_state_nxt = S_SERVE;
          end
        end
        S_SERVE: begin
          if (!startGame)
            w_state_nxt = S_TITLE;
          else if (r_cnt == SERVE_LAST)
            w_state_nxt = S_PLAY;
          else
            w_cnt_nxt = r_cnt + 1'b1;
        end
        S_PLAY: begin
          if (!startGame) begin
            w_state_nxt = S_TITLE;
          end else if (w_off_left) begin
            w_right_nxt = w_right_inc;
            w_x_nxt     = HX;
            w_state_nxt = S_POINT;
          end else if (w_off_right) begin
            w_left_nxt  = w_left_inc;
            w_x_nxt     = HX;
            w_state_nxt = S_POINT;
          end else begin
            w_x_nxt = w_next[9:0];
          end
        end
        S_POINT: begin
          if (!startGame) begin
            w_state_nxt = S_TITLE;
          end else if (r_left == WIN || r_right == WIN) begin
            w_state_nxt = S_WIN;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SERVE;
          end
        end
        S_WIN: begin
          if (!startGame)
            w_state_nxt = S_TITLE;
        end
        default: w_state_nxt = S_TITLE;
      endcase
    end
  end

  always_comb begin
    w_title_nxt = (w_state_nxt == S_TITLE);
    w_wl_nxt    = (w_state_nxt == S_WIN)
                & (w_left_nxt == WIN);
    w_wr_nxt    = (w_state_nxt == S_WIN)
                & (w_right_nxt == WIN);
  end

  assign w_active = (r_state == S_SERVE)
                  | (r_state == S_PLAY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait      <= 1'b0;
      r_adc_start <= 1'b0;
      r_speed     <= '0;
    end else begin
      r_adc_start <= 1'b0;
      if (r_wait) begin
        if (!w_active) begin
          r_wait <= 1'b0;
        end else if (eoc) begin
          r_speed <= moveSpeed;
          r_wait  <= 1'b0;
        end else if (w_to_hit) begin
          r_wait <= 1'b0;
        end
      end else if (screenEnd && w_active) begin
        r_adc_start <= 1'b1;
        r_wait      <= 1'b1;
      end
    end
  end

`ifdef GAME_SEQ_ADC_TIMEOUT_EN
  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ADC_TIMEOUT - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_to_flag;

  assign w_to_hit = r_wait & w_active & ~eoc
                  & (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else begin
      if (!r_wait || w_to_hit)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_hit)
        r_to_flag <= 1'b1;
    end
  end

  assign adc_timeout = r_to_flag;
`else
  assign w_to_hit = 1'b0;
  // no timeout hardware; constant 0 for any legal ADC_TIMEOUT
  assign adc_timeout = (ADC_TIMEOUT < 0);
`endif

  assign adc_start   = r_adc_start;
  assign squareX     = r_x;
  assign squareY     = HY;
  assign leftsc      = r_left;
  assign rightsc     = r_right;
  assign showTitle   = r_title;
  assign winnerLeft  = r_wl;
  assign winnerRight = r_wr;
  assign state       = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed frames against a frame-rule model of the pong controller.
// The model follows the game rules with integers; literal checks pin key positions.
`timescale 1ns/1ps
module tb_game_sequencer;

  localparam int SF  = 4;
  localparam int HX  = 285;
  localparam int HY  = 215;
  localparam int LG  = 160;
  localparam int RG  = 430;
  localparam int WS  = 5;
  localparam int SH  = 5;
  localparam int TO  = 1023;
  localparam int GAP = 8;
`ifdef GAME_SEQ_ADC_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       screenEnd = 1'b0;
  logic       startGame = 1'b0;
  logic       player = 1'b0;
  logic [7:0] moveSpeed;
  logic       eoc;
  logic       adc_start;
  logic [9:0] squareX;
  logic [8:0] squareY;
  logic [7:0] leftsc, rightsc;
  logic       showTitle, winnerLeft, winnerRight;
  logic [2:0] state;
  logic       adc_timeout;

  logic       eoc_auto = 1'b0;
  logic       eoc_man = 1'b0;
  logic [7:0] adc_val = 8'd64;
  logic [7:0] man_val = 8'd0;
  bit         resp_en = 1'b1;
  bit         chk_en = 1'b0;

  assign eoc       = eoc_auto | eoc_man;
  assign moveSpeed = eoc_man ? man_val : adc_val;

  game_sequencer #(.SERVE_FRAMES(SF)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .screenEnd   (screenEnd),
    .startGame   (startGame),
    .player      (player),
    .moveSpeed   (moveSpeed),
    .eoc         (eoc),
    .adc_start   (adc_start),
    .squareX     (squareX),
    .squareY     (squareY),
    .leftsc      (leftsc),
    .rightsc     (rightsc),
    .showTitle   (showTitle),
    .winnerLeft  (winnerLeft),
    .winnerRight (winnerRight),
    .state       (state),
    .adc_timeout (adc_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ADC stand-in: answers a request three cycles later for one cycle
  int rcnt = -1;
  always @(negedge clk) begin
    eoc_auto = (rcnt == 0);
    if (rcnt >= 0) rcnt--;
    if (adc_start && resp_en) rcnt = 2;
  end

  // frame-rule model: phase 0..4 = title, serve, play, point, win
  int m_phase, m_x, m_l, m_r, m_cnt, m_spd, m_wcnt;
  bit m_busy, m_start, m_to, m_title, m_wl, m_wr;
  int ph, sp, nx;
  bit live;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_x = HX; m_l = 0; m_r = 0;
      m_cnt = 0; m_spd = 0; m_wcnt = 0;
      m_busy = 0; m_start = 0; m_to = 0;
      m_title = 1; m_wl = 0; m_wr = 0;
    end else begin
      ph = m_phase;
      sp = m_spd;
      live = (ph == 1 || ph == 2);
      m_start = 0;
      if (m_busy) begin
        if (!live) m_busy = 0;
        else if (eoc) begin
          m_spd = moveSpeed;
          m_busy = 0;
        end
`ifdef GAME_SEQ_ADC_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == TO) begin
            m_busy = 0;
            m_to = 1;
          end
        end
`endif
      end else if (screenEnd && live) begin
        m_start = 1;
        m_busy = 1;
        m_wcnt = 0;
      end
      if (screenEnd) begin
        if (ph != 0 && !startGame) m_phase = 0;
        else case (ph)
          0: if (startGame) begin
            m_l = 0; m_r = 0; m_cnt = 0;
            m_x = HX; m_phase = 1;
          end
          1: begin
            m_x = HX;
            if (m_cnt == SF - 1) m_phase = 2;
            else m_cnt++;
          end
          2: begin
            nx = player ? m_x - sp / (1 << SH)
                        : m_x + sp / (1 << SH);
            if (nx < LG) begin
              if (m_r < 255) m_r++;
              m_x = HX; m_phase = 3;
            end else if (nx > RG) begin
              if (m_l < 255) m_l++;
              m_x = HX; m_phase = 3;
            end else m_x = nx;
          end
          3: begin
            if (m_l == WS || m_r == WS) m_phase = 4;
            else begin
              m_phase = 1; m_cnt = 0;
            end
          end
          default: ;
        endcase
      end
      m_title = (m_phase == 0);
      m_wl = (m_phase == 4) && (m_l == WS);
      m_wr = (m_phase == 4) && (m_r == WS);
    end
  end

  logic [42:0] got_v, exp_v;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      got_v = {state, squareX, squareY, leftsc, rightsc,
               showTitle, winnerLeft, winnerRight,
               adc_start, adc_timeout};
      exp_v = {3'(m_phase), 10'(m_x), 9'(HY), 8'(m_l), 8'(m_r),
               m_title, m_wl, m_wr, m_start, m_to};
      chk("outputs", 64'(got_v), 64'(exp_v));
    end
  end

  task automatic tick(input bit with_eoc, input logic [7:0] v,
                      output int starts);
    starts = 0;
    @(negedge clk);
    screenEnd = 1'b1;
    if (with_eoc) begin
      eoc_man = 1'b1;
      man_val = v;
    end
    @(negedge clk);
    screenEnd = 1'b0;
    eoc_man = 1'b0;
    if (adc_start) starts++;
    repeat (GAP - 1) begin
      @(negedge clk);
      if (adc_start) starts++;
    end
  endtask

  task automatic frame();
    int s;
    tick(1'b0, 8'd0, s);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s;
    @(negedge clk);
    rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_x", 64'(squareX), 64'd285);
    chk("rst_y", 64'(squareY), 64'd215);
    chk("rst_scores", 64'({leftsc, rightsc}), 64'd0);
    chk("rst_title", 64'(showTitle), 64'd1);
    chk("rst_adc", 64'({adc_start, adc_timeout}), 64'd0);

    startGame = 1'b1;
    player = 1'b0;
    adc_val = 8'd64;
    repeat (5) frame();
    chk("play_entry", 64'(state), 64'd2);
    frame();
    chk("x_287", 64'(squareX), 64'd287);
    frame();
    chk("x_289", 64'(squareX), 64'd289);

    player = 1'b1;
    repeat (3) frame();
    adc_val = 8'd255;
    frame();
    chk("x_281", 64'(squareX), 64'd281);
    repeat (17) frame();
    chk("x_162", 64'(squareX), 64'd162);
    frame();
    chk("pt_rsc", 64'(rightsc), 64'd1);
    chk("pt_state", 64'(state), 64'd3);
    chk("pt_home", 64'(squareX), 64'd285);
    frame();
    chk("pt_serve", 64'(state), 64'd1);

    player = 1'b0;
    for (int i = 0; i < 400 && m_phase != 4; i++) frame();
    chk("win_lsc", 64'(leftsc), 64'd5);
    chk("win_rsc", 64'(rightsc), 64'd1);
    chk("win_state", 64'(state), 64'd4);
    chk("win_flags", 64'({winnerLeft, winnerRight}), 64'd2);

    startGame = 1'b0;
    frame();
    chk("title_state", 64'(state), 64'd0);
    chk("title_ovl", 64'(showTitle), 64'd1);
    chk("title_keep", 64'({leftsc, rightsc}), 64'h0501);
    chk("title_flags", 64'({winnerLeft, winnerRight}), 64'd0);
    pulse_reset();
    chk("rst2_scores", 64'({leftsc, rightsc}), 64'd0);

    startGame = 1'b1;
    adc_val = 8'd32;
    repeat (5) frame();
    resp_en = 1'b0;
    frame();
    chk("x_286", 64'(squareX), 64'd286);
    tick(1'b1, 8'd96, s);
    chk("same_x", 64'(squareX), 64'd287);
    chk("same_nostart", 64'(s), 64'd0);
    tick(1'b0, 8'd0, s);
    chk("new_x", 64'(squareX), 64'd290);
    chk("new_start", 64'(s), 64'd1);

    repeat (1000) @(negedge clk);
    chk("to_early", 64'(adc_timeout), 64'd0);
    repeat (100) @(negedge clk);
    chk("to_flag", 64'(adc_timeout), 64'(TO_EN));
    tick(1'b0, 8'd0, s);
    chk("to_restart", 64'(s), 64'(TO_EN));
    chk("to_keep_spd", 64'(squareX), 64'd293);

    pulse_reset();
    chk("rst3_state", 64'(state), 64'd0);
    chk("rst3_x", 64'(squareX), 64'd285);
    chk("rst3_title", 64'(showTitle), 64'd1);
    chk("rst3_to", 64'(adc_timeout), 64'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-level game controller for the square-pong display. It owns the square's X position, both scores and the game phase (title, serve, play, point, win). Once per frame it samples the speed ADC through a start/end-of-conversion handshake. It replaces ad-hoc position logic in the VGA top level: the top level only draws from this block's registered outputs, and `screenEnd` from the timing generator paces every game update.

## Interface
Parameters:
- `SQUARE_DIM`, 50: square edge in pixels (informational; goal limits already account for it).
- `HOME_X`, 285: serve X position.
- `HOME_Y`, 215: constant Y position.
- `LEFT_GOAL`, 160: X below this scores for right.
- `RIGHT_GOAL`, 430: X above this scores for left.
- `WIN_SCORE`, 5: score that ends the game.
- `SPEED_SHIFT`, 5: step = speed >> SPEED_SHIFT.
- `SERVE_FRAMES`, 60: frames held at home before play.
- `ADC_TIMEOUT`, 1023: clk cycles to wait for `eoc`.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low.
- `screenEnd` in 1: one-cycle frame tick.
- `startGame` in 1: level, game enable switch.
- `player` in 1: direction; 1 = move left, 0 = move right.
- `moveSpeed` in 8: ADC result, valid while `eoc` high.
- `eoc` in 1: ADC end of conversion, level.
- `adc_start` out 1: one-cycle conversion request.
- `squareX` out 10: square left edge.
- `squareY` out 9: square top edge, always HOME_Y.
- `leftsc` out 8: left score.
- `rightsc` out 8: right score.
- `showTitle`, `winnerLeft`, `winnerRight` out 1 each: overlay enables.
- `state` out 3: encoded FSM state, for debug.
- `adc_timeout` out 1: sticky flag, set when a conversion timed out.

## Operation
- Reset (any state, asynchronous) forces the following values:
  - state TITLE; `squareX`=HOME_X, `squareY`=HOME_Y.
  - Scores 0, speed register 0, serve counter 0.
  - `adc_start`=0, `adc_timeout`=0, `showTitle`=1, winners 0.
- FSM:
  - State encodings: TITLE=0, SERVE=1, PLAY=2, POINT=3, WIN=4. All transitions are evaluated only on a `screenEnd` cycle.
  - TITLE: when `startGame`=1, clear both scores, serve counter 0, go to SERVE.
  - SERVE: `squareX` held at HOME_X. Counter increments each tick; when it reaches SERVE_FRAMES-1, go to PLAY.
  - PLAY: step = speed_q >> SPEED_SHIFT, zero-extended to 11 bits. next = `squareX` − step if `player`, else + step, computed 11-bit unsigned.
    - Wrap below 0 (bit 10 set on subtract) or next < LEFT_GOAL: `rightsc`+1, go to POINT.
    - next > RIGHT_GOAL: `leftsc`+1, go to POINT.
    - Otherwise `squareX` = next[9:0].
  - POINT: `squareX` = HOME_X on entry. Next tick: either score == WIN_SCORE → WIN, else SERVE with counter 0.
  - WIN: `winnerLeft` = (`leftsc` == WIN_SCORE), `winnerRight` = (`rightsc` == WIN_SCORE). When `startGame`=0, go to TITLE.
  - `startGame`=0 in SERVE, PLAY or POINT → TITLE. Scores are retained until the next start.
- `showTitle` = 1 exactly in TITLE.
- Scores saturate at 255; they cannot pass WIN_SCORE in normal play.
- ADC handshake, active in SERVE and PLAY only:
  - On a tick with the handshake idle, pulse `adc_start` for one cycle and enter WAIT.
  - In WAIT, the first cycle with `eoc`=1 latches `moveSpeed` into speed_q and returns to idle.
  - A tick arriving during WAIT issues no new start.
  - Leaving SERVE/PLAY aborts WAIT; speed_q keeps its value.

## Timing
- All outputs are registered and update on the clk edge following the `screenEnd` cycle; position latency is 1 cycle.
- `adc_start` goes high the cycle after the tick, for exactly one cycle.
- speed_q updates the cycle after `eoc` is sampled high.
- Tick and `eoc` in the same cycle: the step uses the old speed_q.
- Scores and `squareX` change on the same edge as the transition into POINT.

## Configuration
- `GAME_SEQ_ADC_TIMEOUT_EN` defined:
  - A WAIT cycle counter runs.
  - After ADC_TIMEOUT cycles without `eoc`, the handshake returns to idle, speed_q is kept, and `adc_timeout` is set (cleared only by reset).
- Undefined: WAIT lasts until `eoc`, with no counter; `adc_timeout` is tied 0.

## Test plan
- Reset mid-PLAY with `squareX`=300, scores 2/3 → next cycle: TITLE, `squareX`=285, scores 0, `showTitle`=1.
- `startGame`=1, tick; SERVE_FRAMES=4 → PLAY on the 5th tick. `eoc` returns `moveSpeed`=64, `player`=0 → `squareX` advances 285→287→289 per tick.
- `player`=1, speed 255 (step 7), `squareX`=162 → tick gives `rightsc`=1, state POINT, `squareX`=285; next tick → SERVE.
- `leftsc`=4, crossing RIGHT_GOAL → `leftsc`=5, POINT → WIN with `winnerLeft`=1; then `startGame`=0, tick → TITLE.
- `eoc` never asserted, macro defined → `adc_timeout`=1 after 1023 cycles, speed unchanged. Macro undefined → no `adc_start` on later ticks.
- Tick with `eoc`=1 in the same cycle carrying 96, old speed 32 → step 1 this frame, step 3 next frame.
